// File: rtl/led_matrix_pkg.sv
//============================================================================
// led_matrix_pkg: shared scan-state type and helpers for the LED matrix scanner
// Revision: 1.0
//============================================================================
`default_nettype none

package led_matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    // Widest row or column vector the polarity helper handles.
    localparam int POL_W = 64;

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [POL_W-1:0] apply_polarity(input logic [POL_W-1:0] vec,
                                                        input logic             active_low);
        return active_low ? ~vec : vec;
    endfunction

    // Column 0 lives in the MSBs of the packed frame.
    function automatic int slice_lsb(input int col, input int num_cols, input int num_rows);
        return (num_cols - 1 - col) * num_rows;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_scan_timer.sv
//============================================================================
// led_scan_timer: dwell counter, column ring, wrap strobe and frame_start
// Revision: 1.0
//============================================================================
`default_nettype none

module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int NUM_COLS     = 5,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int COL_W        = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             has_frame,
    output scan_state_t      state,
    output scan_state_t      state_nxt,
    output logic [COL_W-1:0] col_nxt,
    output logic [COL_W-1:0] col_index,
    output logic             frame_start,
    output logic             wrap
);

    localparam int               DW         = index_width(DWELL_CYCLES);
    localparam logic [DW-1:0]    LAST_DWELL = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0]    LAST_BLANK = DW'(BLANK_CYCLES - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam scan_state_t      FIRST_ST   = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

    scan_state_t      r_state;
    logic [DW-1:0]    r_dwell;
    logic [DW-1:0]    w_dwell_nxt;
    logic [COL_W-1:0] r_col;
    logic             r_frame_start;
    logic             w_frame_start_nxt;

    assign state       = r_state;
    assign col_index   = r_col;
    assign frame_start = r_frame_start;

    always_comb begin
        state_nxt   = r_state;
        w_dwell_nxt = r_dwell;
        col_nxt     = r_col;
        wrap        = 1'b0;
        if (!enable) begin
            state_nxt   = ST_IDLE;
            w_dwell_nxt = '0;
            col_nxt     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_dwell_nxt = '0;
                    col_nxt     = '0;
                    if (has_frame) state_nxt = FIRST_ST;
                end
                ST_BLANK: begin
                    w_dwell_nxt = r_dwell + 1'b1;
                    if (r_dwell == LAST_BLANK) state_nxt = ST_ON;
                end
                ST_ON: begin
                    if (r_dwell == LAST_DWELL) begin
                        w_dwell_nxt = '0;
                        state_nxt   = FIRST_ST;
                        if (r_col == LAST_COL) begin
                            col_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            col_nxt = r_col + 1'b1;
                        end
                    end else begin
                        w_dwell_nxt = r_dwell + 1'b1;
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    w_dwell_nxt = '0;
                    col_nxt     = '0;
                end
            endcase
        end
        // Registered alongside the state so the pulse lines up with slot 0 of column 0.
        w_frame_start_nxt = (state_nxt != ST_IDLE) && (w_dwell_nxt == '0) && (col_nxt == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_dwell       <= '0;
            r_col         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= state_nxt;
            r_dwell       <= w_dwell_nxt;
            r_col         <= col_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_matrix_scanner.sv
//============================================================================
// led_matrix_scanner: double-buffered, time-multiplexed column-strobe LED driver
// Revision: 1.0
//============================================================================
`default_nettype none

module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int NUM_COLS       = 5,
    parameter int NUM_ROWS       = 8,
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int COL_ACTIVE_LOW = 1,
    parameter int ROW_ACTIVE_LOW = 0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [NUM_COLS*NUM_ROWS-1:0]       frame_data,
    input  logic                               frame_valid,
    output logic                               frame_ready,
    output logic [NUM_COLS-1:0]                col_drive,
    output logic [NUM_ROWS-1:0]                row_drive,
    output logic [index_width(NUM_COLS)-1:0]   col_index,
    output logic                               frame_start
);

    localparam int   FW      = NUM_COLS * NUM_ROWS;
    localparam int   COL_W   = index_width(NUM_COLS);
    localparam int   LSB_W   = index_width(FW);
    localparam logic COL_OFF = (COL_ACTIVE_LOW != 0);
    localparam logic ROW_OFF = (ROW_ACTIVE_LOW != 0);

    scan_state_t      w_state;
    scan_state_t      w_state_nxt;
    logic [COL_W-1:0] w_col_nxt;
    logic             w_wrap;

    logic [FW-1:0]       r_active;
    logic [FW-1:0]       r_pending;
    logic                r_pending_full;
    logic                r_has_frame;
    logic [NUM_COLS-1:0] r_col_drive;
    logic [NUM_ROWS-1:0] r_row_drive;

    logic                w_accept;
    logic                w_commit;
    logic [FW-1:0]       w_active_nxt;
    logic [LSB_W-1:0]    w_lsb;
    logic [NUM_COLS-1:0] w_col_act;
    logic [NUM_ROWS-1:0] w_row_act;

    led_scan_timer #(
        .NUM_COLS     (NUM_COLS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .COL_W        (COL_W)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .has_frame   (r_has_frame),
        .state       (w_state),
        .state_nxt   (w_state_nxt),
        .col_nxt     (w_col_nxt),
        .col_index   (col_index),
        .frame_start (frame_start),
        .wrap        (w_wrap)
    );

    // The pending slot frees on the wrap edge, so a held frame is taken in that same cycle.
    assign frame_ready  = ~r_pending_full | w_wrap;
    assign w_accept     = frame_valid & frame_ready;
    assign w_commit     = r_pending_full & (w_wrap | ((w_state == ST_IDLE) & ~r_has_frame));
    assign w_active_nxt = w_commit ? r_pending : r_active;
    assign w_lsb        = LSB_W'(slice_lsb(int'(w_col_nxt), NUM_COLS, NUM_ROWS));

    assign col_drive = r_col_drive;
    assign row_drive = r_row_drive;

    always_comb begin
        w_col_act = '0;
        w_row_act = '0;
        if (w_state_nxt == ST_ON) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                w_col_act[NUM_COLS-1-c] = (w_col_nxt == COL_W'(c));
            end
            w_row_act = w_active_nxt[w_lsb +: NUM_ROWS];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_has_frame    <= 1'b0;
            r_col_drive    <= {NUM_COLS{COL_OFF}};
            r_row_drive    <= {NUM_ROWS{ROW_OFF}};
        end else begin
            if (w_accept) begin
                r_pending      <= frame_data;
                r_pending_full <= 1'b1;
            end else if (w_commit) begin
                r_pending_full <= 1'b0;
            end
            if (w_commit) begin
                r_active    <= r_pending;
                r_has_frame <= 1'b1;
            end
            r_col_drive <= NUM_COLS'(apply_polarity(POL_W'(w_col_act), COL_OFF));
            r_row_drive <= NUM_ROWS'(apply_polarity(POL_W'(w_row_act), ROW_OFF));
        end
    end

endmodule

`default_nettype wire
